// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the decode/ALU stage and the mult/div unit.
// master: decoder side (drives start/funct/op1/op2); slave: the unit (drives busy/done/hi/lo).
interface mips_muldiv_if;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, funct, op1, op2,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, funct, op1, op2,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Multicycle MIPS multiply/divide unit owning the architectural HI/LO registers.
// Ports: clk, reset (sync, active-high), bus (mips_muldiv_if.slave: start/funct/op1/op2 in;
// busy/done/hi/lo out). MULT/MULTU take MULT_CYCLES, DIV/DIVU take DIV_CYCLES+1 cycles.
module mips_muldiv_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic          clk,
    input  logic          reset,
    mips_muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    localparam int MAX_C = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_C) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               done_q, done_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               sgn_q, sgn_d;
    logic [31:0]        rem_q, rem_d;
    logic [31:0]        quot_q, quot_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;

    // funct decode, one-hot by construction
    logic f_mul, f_div, f_mthi, f_mtlo;
    assign f_mul  = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
    assign f_div  = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
    assign f_mthi = (bus.funct == F_MTHI);
    assign f_mtlo = (bus.funct == F_MTLO);

    logic        divs;
    logic [31:0] abs1, abs2;
    assign divs = (bus.funct == F_DIV);
    assign abs1 = bus.op1[31] ? -bus.op1 : bus.op1;
    assign abs2 = bus.op2[31] ? -bus.op2 : bus.op2;

    // 64-bit product from the latched operands; sign extension only for MULT
    logic [63:0] ext_a, ext_b, prod;
    assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
    assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    // One restoring-division step. quot_q starts as the dividend and is shifted
    // out from the top while quotient bits enter at the bottom. The shifted
    // remainder needs 33 bits; when it fits, the 32-bit difference is exact.
    logic [32:0] rem_ext;
    logic        ge;
    logic [31:0] rem_n, quot_n;
    assign rem_ext = {rem_q, quot_q[31]};
    assign ge      = rem_ext >= {1'b0, b_q};
    assign rem_n   = ge ? (rem_ext[31:0] - b_q) : rem_ext[31:0];
    assign quot_n  = {quot_q[30:0], ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        negq_d  = negq_q;
        negr_d  = negr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    unique case (1'b1)
                        f_mul: begin
                            a_d     = bus.op1;
                            b_d     = bus.op2;
                            sgn_d   = (bus.funct == F_MULT);
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            state_d = MUL;
                        end
                        f_div: begin
                            quot_d  = divs ? abs1 : bus.op1;
                            b_d     = divs ? abs2 : bus.op2;
                            rem_d   = '0;
                            // all-ones quotient on /0 must not be negated
                            negq_d  = divs && (bus.op1[31] ^ bus.op2[31])
                                      && (bus.op2 != '0);
                            negr_d  = divs && bus.op1[31];
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            state_d = DIV;
                        end
                        f_mthi: hi_d = bus.op1;
                        f_mtlo: lo_d = bus.op1;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV: begin
                rem_d  = rem_n;
                quot_d = quot_n;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                lo_d    = negq_q ? -quot_q : quot_q;
                hi_d    = negr_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quot_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed testbench for mips_muldiv_unit.
// Drives the interface as decoder master; checks HI/LO, busy, done and latencies.
module tb_mips_muldiv_unit;

    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_muldiv_if bus ();

    mips_muldiv_unit #(
        .MULT_CYCLES(4),
        .DIV_CYCLES(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // start held across exactly one rising edge; returns #1 after that edge
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.funct = f;
        bus.op1   = a;
        bus.op2   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // lat = edges after accept until done is seen (-1 on timeout)
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output bit held);
        logic [31:0] h0, l0;
        h0 = bus.hi;
        l0 = bus.lo;
        issue(f, a, b);
        lat = -1;
        busy_cnt = 0;
        held = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (bus.busy) begin
                busy_cnt++;
                if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.funct = '0;
        bus.op1 = '0;
        bus.op2 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", bus.hi, bus.lo);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
        end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int lat, bc;
        bit held;
        run_op(F_MULT, 32'hFFFFFFFF, 32'h2, lat, bc, held);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL mult_lat: got %0d expected 4", lat);
        end
        checks++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL mult_neg: got hi=%h lo=%h expected ffffffff/fffffffe", bus.hi, bus.lo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mult_done_pulse: got done=%b expected 0", bus.done);
        end
        run_op(F_MULT, 32'h80000000, 32'h80000000, lat, bc, held);
        checks++;
        if (bus.hi !== 32'h40000000 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL mult_minmin: got hi=%h lo=%h expected 40000000/0", bus.hi, bus.lo);
        end
        run_op(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, held);
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h1) begin
            errors++;
            $display("FAIL mult_m1m1: got hi=%h lo=%h expected 0/1", bus.hi, bus.lo);
        end
    endtask

    task automatic test_multu();
        int lat, bc;
        bit held;
        run_op(F_MULTU, 32'hFFFFFFFF, 32'h2, lat, bc, held);
        checks++;
        if (bc !== 4 || lat !== 4) begin
            errors++;
            $display("FAIL multu_busy: got busy=%0d lat=%0d expected 4/4", bc, lat);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL multu_hold: got hilo changed expected held while busy");
        end
        checks++;
        if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL multu_res: got hi=%h lo=%h expected 1/fffffffe", bus.hi, bus.lo);
        end
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, held);
        checks++;
        if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h1) begin
            errors++;
            $display("FAIL multu_max: got hi=%h lo=%h expected fffffffe/1", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        int lat, bc;
        bit held;
        run_op(F_DIV, 32'hFFFFFFF9, 32'h2, lat, bc, held);
        checks++;
        if (lat !== 33 || !held) begin
            errors++;
            $display("FAIL div_lat: got lat=%0d held=%b expected 33/1", lat, held);
        end
        checks++;
        if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL div_neg: got lo=%h hi=%h expected fffffffd/ffffffff", bus.lo, bus.hi);
        end
        run_op(F_DIV, 32'h7, 32'hFFFFFFFE, lat, bc, held);
        checks++;
        if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'h1) begin
            errors++;
            $display("FAIL div_negdiv: got lo=%h hi=%h expected fffffffd/1", bus.lo, bus.hi);
        end
        run_op(F_DIVU, 32'h7, 32'h2, lat, bc, held);
        checks++;
        if (bus.lo !== 32'h3 || bus.hi !== 32'h1 || lat !== 33) begin
            errors++;
            $display("FAIL divu: got lo=%h hi=%h lat=%0d expected 3/1/33", bus.lo, bus.hi, lat);
        end
        run_op(F_DIVU, 32'hFFFFFFFF, 32'h10, lat, bc, held);
        checks++;
        if (bus.lo !== 32'h0FFFFFFF || bus.hi !== 32'hF) begin
            errors++;
            $display("FAIL divu_big: got lo=%h hi=%h expected 0fffffff/f", bus.lo, bus.hi);
        end
    endtask

    task automatic test_div_edge();
        int lat, bc;
        bit held;
        run_op(F_DIVU, 32'h7, 32'h0, lat, bc, held);
        checks++;
        if (bus.lo !== 32'hFFFFFFFF || bus.hi !== 32'h7 || lat !== 33) begin
            errors++;
            $display("FAIL divu_zero: got lo=%h hi=%h lat=%0d expected ffffffff/7/33", bus.lo, bus.hi, lat);
        end
        run_op(F_DIV, 32'hFFFFFFF9, 32'h0, lat, bc, held);
        checks++;
        if (bus.lo !== 32'hFFFFFFFF || bus.hi !== 32'hFFFFFFF9) begin
            errors++;
            $display("FAIL div_zero: got lo=%h hi=%h expected ffffffff/fffffff9", bus.lo, bus.hi);
        end
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc, held);
        checks++;
        if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0) begin
            errors++;
            $display("FAIL div_ovf: got lo=%h hi=%h expected 80000000/0", bus.lo, bus.hi);
        end
    endtask

    task automatic test_mthi_mtlo();
        bit busy_seen;
        logic [31:0] h0, l0;
        busy_seen = 1'b0;
        issue(F_MTHI, 32'h1234, 32'h0);
        if (bus.busy || bus.done) busy_seen = 1'b1;
        issue(F_MTLO, 32'h5678, 32'h0);
        if (bus.busy || bus.done) busy_seen = 1'b1;
        @(posedge clk);
        #1;
        if (bus.busy || bus.done) busy_seen = 1'b1;
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
            errors++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h expected 1234/5678", bus.hi, bus.lo);
        end
        checks++;
        if (busy_seen) begin
            errors++;
            $display("FAIL mtx_busy: got busy/done set expected never");
        end
        h0 = bus.hi;
        l0 = bus.lo;
        issue(6'd32, 32'hDEAD, 32'hBEEF);
        if (bus.busy) busy_seen = 1'b1;
        checks++;
        if (busy_seen || bus.hi !== h0 || bus.lo !== l0) begin
            errors++;
            $display("FAIL bad_funct: got busy=%b hi=%h lo=%h expected ignored", busy_seen, bus.hi, bus.lo);
        end
    endtask

    task automatic test_ignore_while_busy();
        int lat, dones;
        issue(F_DIVU, 32'h7, 32'h2);
        repeat (5) @(posedge clk);
        #1;
        issue(F_MTHI, 32'h1234, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        issue(F_MULTU, 32'h3, 32'h3);
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (lat < 0 || bus.hi !== 32'h1 || bus.lo !== 32'h3) begin
            errors++;
            $display("FAIL busy_ignore: got lat=%0d hi=%h lo=%h expected done/1/3", lat, bus.hi, bus.lo);
        end
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones !== 0 || bus.hi !== 32'h1 || bus.lo !== 32'h3) begin
            errors++;
            $display("FAIL busy_ignore_late: got extra=%0d hi=%h lo=%h expected 0/1/3", dones, bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid_div();
        int lat, bc, dones;
        bit held;
        issue(F_MTHI, 32'hAAAA, 32'h0);
        issue(F_MTLO, 32'hBBBB, 32'h0);
        issue(F_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy: got busy=%b expected 1", bus.busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_div: got busy=%b hi=%h lo=%h done=%b expected 0/0/0/0",
                     bus.busy, bus.hi, bus.lo, bus.done);
        end
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) dones++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d active cycles expected 0", dones);
        end
        run_op(F_MULT, 32'd3, 32'd5, lat, bc, held);
        checks++;
        if (bus.lo !== 32'd15 || bus.hi !== 32'h0 || lat !== 4) begin
            errors++;
            $display("FAIL rst_then_mult: got lo=%h hi=%h lat=%0d expected f/0/4", bus.lo, bus.hi, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        bit held;
        run_op(F_MULTU, 32'd6, 32'd7, lat, bc, held);
        checks++;
        if (bus.lo !== 32'd42 || bus.hi !== 32'h0) begin
            errors++;
            $display("FAIL b2b_first: got lo=%h hi=%h expected 2a/0", bus.lo, bus.hi);
        end
        // next request issued in the done cycle itself
        run_op(F_DIVU, 32'd100, 32'd7, lat, bc, held);
        checks++;
        if (lat !== 33 || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            errors++;
            $display("FAIL b2b_div: got lat=%0d lo=%h hi=%h expected 33/e/2", lat, bus.lo, bus.hi);
        end
        run_op(F_MULT, 32'hFFFFFFFD, 32'd5, lat, bc, held);
        checks++;
        if (lat !== 4 || bus.lo !== 32'hFFFFFFF1 || bus.hi !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL b2b_mult: got lat=%0d lo=%h hi=%h expected 4/fffffff1/ffffffff", lat, bus.lo, bus.hi);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_edge();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_reset_mid_div();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
